// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module : seg_disp_pkg
// Brief  : Shared types for the seven-segment display arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_disp_pkg;

    localparam int DISP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Round-robin pick of the first set request after last_id, wrapping
//          so that last_id itself is the last candidate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               valid,
    output logic [ID_W-1:0]    next_id
);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        valid   = 1'b0;
        next_id = last_id;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[ID_W'((int'(last_id) + k) % NUM_REQ)]) begin
                valid   = 1'b1;
                next_id = ID_W'((int'(last_id) + k) % NUM_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module : seg_display_arbiter
// Brief  : Round-robin owner of the 8-digit display path with minimum dwell
//          and a blank gap between owners.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DWELL_CYCLES = 8,
    parameter  int BLANK_CYCLES = 2,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DISP_W-1:0] value_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ID_W-1:0]           owner_id,
    output logic [DISP_W-1:0]         sixteen_bit_number,
    output logic                      blank
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);

    state_t              state, state_nxt;
    logic [DW_W-1:0]     dwell_cnt, dwell_nxt;
    logic [BL_W-1:0]     blank_cnt, blank_cnt_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [ID_W-1:0]     owner_nxt;
    logic [DISP_W-1:0]   number_nxt;
    logic                blank_nxt;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic [DISP_W-1:0]   owner_value;
    logic                owner_req;
    logic                others_req;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req),
        .last_id (owner_id),
        .valid   (pick_valid),
        .next_id (pick_id)
    );

    always_comb begin
        owner_value = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_id == ID_W'(i)) begin
                owner_value = value_in[i*DISP_W +: DISP_W];
            end
        end
    end

    assign owner_req  = req[owner_id];
    assign others_req = |(req & ~(NUM_REQ'(1) << owner_id));

    always_comb begin
        state_nxt     = state;
        dwell_nxt     = dwell_cnt;
        blank_cnt_nxt = blank_cnt;
        grant_nxt     = grant;
        owner_nxt     = owner_id;
        number_nxt    = sixteen_bit_number;
        blank_nxt     = blank;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick_id;
                    grant_nxt = NUM_REQ'(1) << pick_id;
                    dwell_nxt = '0;
                    blank_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                number_nxt = owner_value;
                dwell_nxt  = dwell_cnt + 1'b1;
                // A dwell that ends with a rival waiting skips HOLD, whose exit would already be true.
                if (!owner_req || (dwell_cnt == DW_W'(DWELL_CYCLES - 1) && others_req)) begin
                    state_nxt     = ST_BLANK;
                    grant_nxt     = '0;
                    blank_nxt     = 1'b1;
                    blank_cnt_nxt = '0;
                end else if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                number_nxt = owner_value;
                if (!owner_req || others_req) begin
                    state_nxt     = ST_BLANK;
                    grant_nxt     = '0;
                    blank_nxt     = 1'b1;
                    blank_cnt_nxt = '0;
                end
            end
            ST_BLANK: begin
                if (blank_cnt == BL_W'(BLANK_CYCLES - 1)) begin
                    if (pick_valid) begin
                        state_nxt = ST_GRANT;
                        owner_nxt = pick_id;
                        grant_nxt = NUM_REQ'(1) << pick_id;
                        dwell_nxt = '0;
                        blank_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    blank_cnt_nxt = blank_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            dwell_cnt          <= '0;
            blank_cnt          <= '0;
            grant              <= '0;
            owner_id           <= ID_W'(NUM_REQ - 1);
            sixteen_bit_number <= '0;
            blank              <= 1'b1;
        end else begin
            state              <= state_nxt;
            dwell_cnt          <= dwell_nxt;
            blank_cnt          <= blank_cnt_nxt;
            grant              <= grant_nxt;
            owner_id           <= owner_nxt;
            sixteen_bit_number <= number_nxt;
            blank              <= blank_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module : tb_seg_display_arbiter
// Brief  : Directed self-checking bench for seg_display_arbiter (4 req, 8/2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    localparam int NUM_REQ = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] value_in;
    logic [3:0]  grant;
    logic [1:0]  owner_id;
    logic [15:0] sixteen_bit_number;
    logic        blank;

    int errors = 0;
    int checks = 0;

    seg_display_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req                (req),
        .value_in           (value_in),
        .grant              (grant),
        .owner_id           (owner_id),
        .sixteen_bit_number (sixteen_bit_number),
        .blank              (blank)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_g [5];
        logic [15:0] exp_v [5];
        int n;
        int b;
        int blank_bad;

        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_v[0] = 16'hA5A5; exp_v[1] = 16'h1234; exp_v[2] = 16'hC0DE;
        exp_v[3] = 16'hBEEF; exp_v[4] = 16'hA5A5;

        // 1: reset held with all requests up
        reset    = 1'b1;
        req      = 4'b1111;
        value_in = {16'hBEEF, 16'hC0DE, 16'h1234, 16'hA5A5};
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_grant", grant, 4'b0000);
            check_eq("rst_blank", blank, 1'b1);
            check_eq("rst_number", sixteen_bit_number, 16'h0000);
            check_eq("rst_owner", owner_id, 2'd3);
        end

        // 2: sole requester 1
        reset = 1'b0;
        req   = 4'b0010;
        tick();
        check_eq("t2_grant", grant, 4'b0010);
        check_eq("t2_owner", owner_id, 2'd1);
        check_eq("t2_blank", blank, 1'b0);
        tick();
        check_eq("t2_number", sixteen_bit_number, 16'h1234);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("t2_hold_grant", grant, 4'b0010);
            check_eq("t2_hold_number", sixteen_bit_number, 16'h1234);
            check_eq("t2_hold_blank", blank, 1'b0);
        end

        // 3: full rotation from IDLE after reset
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            check_eq("t3_first_grant", grant, exp_g[g]);
            n = 0;
            while (grant == exp_g[g] && n < 40) begin
                n++;
                if (n == 2) check_eq("t3_number", sixteen_bit_number, exp_v[g]);
                check_eq("t3_blank_low", blank, 1'b0);
                tick();
            end
            check_eq("t3_grant_len", n, 8);
            if (g < 4) begin
                b = 0;
                blank_bad = 0;
                while (grant == 4'b0000 && b < 20) begin
                    b++;
                    if (blank !== 1'b1) blank_bad++;
                    tick();
                end
                check_eq("t3_gap_len", b, 2);
                check_eq("t3_gap_blank", blank_bad, 0);
            end
        end

        // 4: sole requester 0 releases on its third granted cycle
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b0001;
        tick();
        check_eq("t4_grant_c1", grant, 4'b0001);
        tick();
        check_eq("t4_grant_c2", grant, 4'b0001);
        tick();
        check_eq("t4_grant_c3", grant, 4'b0001);
        req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t4_grant_off", grant, 4'b0000);
            check_eq("t4_blank_on", blank, 1'b1);
        end

        // 5: requester 3 interrupts requester 1 in HOLD (owner_id is 0 here)
        req = 4'b0010;
        tick();
        check_eq("t5_grant1", grant, 4'b0010);
        for (int i = 0; i < 28; i++) begin
            tick();
            check_eq("t5_hold_grant", grant, 4'b0010);
        end
        req = 4'b1010;
        tick();
        check_eq("t5_drop", grant, 4'b0000);
        check_eq("t5_drop_blank", blank, 1'b1);
        check_eq("t5_num_held", sixteen_bit_number, 16'h1234);
        tick();
        check_eq("t5_gap2", grant, 4'b0000);
        tick();
        check_eq("t5_grant3", grant, 4'b1000);
        check_eq("t5_owner3", owner_id, 2'd3);
        tick();
        check_eq("t5_number", sixteen_bit_number, 16'hBEEF);
        value_in[63:48] = 16'h5A5A;
        tick();
        check_eq("t5_track", sixteen_bit_number, 16'h5A5A);

        // 6: reset pulse on the fourth granted cycle of requester 2
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_idle", grant, 4'b0000);
        req = 4'b0100;
        tick();
        check_eq("t6_grant_c1", grant, 4'b0100);
        tick();
        tick();
        tick();
        check_eq("t6_grant_c4", grant, 4'b0100);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_grant", grant, 4'b0000);
        check_eq("t6_rst_blank", blank, 1'b1);
        check_eq("t6_rst_number", sixteen_bit_number, 16'h0000);
        check_eq("t6_rst_owner", owner_id, 2'd3);
        reset = 1'b0;
        tick();
        check_eq("t6_regrant", grant, 4'b0100);
        check_eq("t6_reowner", owner_id, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
